// File: rtl/frecuenc_div.sv
// frecuenc_div: free-running B-bit binary counter whose MSB is the divided
// clock NFrec (f_clk / 2^B, 50 % duty). The output comes straight from a
// counter flop, so no decode logic sits between the register and the pin.
module frecuenc_div #(
    parameter int unsigned B = 3
) (
    input  logic cLocK,
    input  logic rst_n,
    output logic NFrec
);

    logic [B-1:0] cnt_q;
    logic [B-1:0] cnt_d;

    // Next count: plain increment, wrapping naturally modulo 2^B.
    always_comb begin
        cnt_d = cnt_q + B'(1);
    end

    // Counter register; synchronous active-low reset takes priority over counting.
    always_ff @(posedge cLocK) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign NFrec = cnt_q[B-1];

endmodule

// File: tb/tb_frecuenc_div.sv
// Bench for frecuenc_div: three instances (B = 1, 3, 5) share clock and reset.
// The reference model counts rising edges since the last reset edge and
// derives each expected output from the phase within a 2^B-cycle period.
module tb_frecuenc_div;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #25 clk = ~clk;   // 50 ns period

    logic n1, n3, n5;
    logic [2:0] cnt3;

    frecuenc_div #(.B(1)) u1 (.cLocK(clk), .rst_n(rst_n), .NFrec(n1));
    frecuenc_div #(.B(3)) u3 (.cLocK(clk), .rst_n(rst_n), .NFrec(n3));
    frecuenc_div #(.B(5)) u5 (.cLocK(clk), .rst_n(rst_n), .NFrec(n5));

    assign cnt3 = u3.cnt_q;

    // ---------------- scoreboard counters ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // k = rising edges seen since the last edge with rst_n low.
    int k = 0;
    bit model_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            k = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            k = k + 1;
        end
    end

    function automatic logic exp_out(input int b, input int kk);
        int p;
        p = 1 << b;
        return ((kk % p) >= (p / 2)) ? 1'b1 : 1'b0;
    endfunction

    // ---------------- per-cycle compare process ----------------
    always @(negedge clk) begin
        if (model_valid) begin
            chk("model_n1", {31'd0, n1}, {31'd0, exp_out(1, k)});
            chk("model_n3", {31'd0, n3}, {31'd0, exp_out(3, k)});
            chk("model_n5", {31'd0, n5}, {31'd0, exp_out(5, k)});
            chk("model_cnt3", {29'd0, cnt3}, 32'(k % 8));
        end
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int rises;
        int highs;
        logic prev;
        time t_rise[$];
        int k_before;

        // Reset held for 3 edges: everything at 0 after each one.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_n3", {31'd0, n3}, 32'd0);
            chk("reset_cnt3", {29'd0, cnt3}, 32'd0);
        end

        // Release and run 32 cycles with literal pins on key edges.
        rst_n = 1'b1;
        rises = 0;
        highs = 0;
        prev = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (n3 && !prev) begin
                rises++;
                t_rise.push_back($time);
            end
            if (n3) highs++;
            prev = n3;
            if (i == 1) chk("first_cnt_is_1", {29'd0, cnt3}, 32'd1);
            if (i == 3) chk("n3_low_edge3", {31'd0, n3}, 32'd0);
            if (i == 4) chk("n3_rise_edge4", {31'd0, n3}, 32'd1);
            if (i == 7) chk("cnt3_at_7", {29'd0, cnt3}, 32'd7);
            if (i == 8) begin
                chk("wrap_cnt3_0", {29'd0, cnt3}, 32'd0);
                chk("wrap_n3_fall", {31'd0, n3}, 32'd0);
            end
            if (i == 1) chk("n1_edge1", {31'd0, n1}, 32'd1);
            if (i == 2) chk("n1_edge2", {31'd0, n1}, 32'd0);
            if (i == 15) chk("n5_edge15", {31'd0, n5}, 32'd0);
            if (i == 16) chk("n5_edge16", {31'd0, n5}, 32'd1);
            if (i == 32) chk("n5_edge32", {31'd0, n5}, 32'd0);
        end
        chk("n3_rises_in_32", 32'(rises), 32'd4);
        chk("n3_high_cycles_in_32", 32'(highs), 32'd16);
        if (t_rise.size() >= 2) begin
            chk("n3_period_ns", 32'(t_rise[1] - t_rise[0]), 32'd400);
        end else begin
            chk("n3_rise_count_for_period", 32'(t_rise.size()), 32'd2);
        end

        // Advance to cnt = 6 (k = 38), then a one-edge reset mid-count.
        repeat (6) @(negedge clk);
        chk("pre_reset_cnt6", {29'd0, cnt3}, 32'd6);
        chk("pre_reset_n3_high", {31'd0, n3}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_reset_n3", {31'd0, n3}, 32'd0);
        chk("mid_reset_cnt3", {29'd0, cnt3}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("after_reset_edge3_low", {31'd0, n3}, 32'd0);
        @(negedge clk);
        chk("after_reset_edge4_rise", {31'd0, n3}, 32'd1);

        // Short low pulse on rst_n between edges must be ignored.
        k_before = k;
        #5 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        @(negedge clk);
        chk("async_pulse_cnt3", {29'd0, cnt3}, 32'((k_before + 1) % 8));
        chk("async_pulse_n5", {31'd0, n5}, {31'd0, exp_out(5, k_before + 1)});

        // Randomized run with sporadic resets; compare process checks every cycle.
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 24) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
